// File: rtl/cgra_apb_master.sv
// APB3 requester: turns a valid/ready command stream into single APB transfers and returns
// the slave response on a valid/ready channel. Optional ACCESS-phase timeout: CGRA_APB_TIMEOUT_EN.
module cgra_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  busy
);

    // state  | meaning
    // IDLE   | waiting for a command
    // SETUP  | APB setup phase (psel=1, penable=0), one cycle
    // ACCESS | APB access phase, waiting on pready
    // RESP   | response presented until rsp_ready
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t                state_q, state_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

`ifdef CGRA_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;

    assign tmo_hit = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef CGRA_APB_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
`ifdef CGRA_APB_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // pready on the final count still completes normally
                if (pready) begin
                    rdata_d = pwrite_q ? '0 : prdata;
                    err_d   = pslverr;
                    state_d = S_RESP;
                end
`ifdef CGRA_APB_TIMEOUT_EN
                else if (tmo_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef CGRA_APB_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef CGRA_APB_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = !cmd_ready;
    assign psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign penable   = (state_q == S_ACCESS);
    assign rsp_valid = (state_q == S_RESP);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_cgra_apb_master.sv
// Randomized scoreboard bench for cgra_apb_master: memory-backed APB slave model,
// reference memory predicting every response, decoupled response monitor.
module tb_cgra_apb_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr, busy;

    cgra_apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int unsigned   rsp_cyc;
        int            hold;
    } exp_t;

    exp_t          sb_q[$];
    int            slave_stall_q[$];
    logic [DW-1:0] ref_mem[64];
    logic [DW-1:0] slave_mem[64];
    logic          cur_write = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;

    // Slaves answer with pslverr for the 0x40..0x4F window; errored writes are dropped.
    function automatic logic addr_err(input logic [AW-1:0] a);
        return a[7:4] == 4'h4;
    endfunction

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int stall, input int hold, input bit track,
                         output int unsigned hs);
        exp_t e;
        bit   abort;
        int   n;
        abort = 1'b0;
`ifdef CGRA_APB_TIMEOUT_EN
        abort = (stall >= TO);
`endif
        slave_stall_q.push_back(stall);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 64'd0, 64'd1);
            cmd_valid = 1'b0;
            hs = 0;
            return;
        end
        cur_write = w; cur_addr = a; cur_wdata = d;
        hs = cyc + 1;
        e.hold = hold;
        if (abort) begin
            e.rdata = '0; e.err = 1'b1; e.rsp_cyc = hs + 1 + TO;
        end else begin
            e.err     = addr_err(a);
            e.rdata   = w ? '0 : ref_mem[a[7:2]];
            e.rsp_cyc = hs + 2 + stall;
            if (track && w && !e.err) ref_mem[a[7:2]] = d;
        end
        if (track) sb_q.push_back(e);
        @(posedge clk);
        #1;
        // keep cmd_valid up with junk fields while busy: must be ignored
        cmd_write = ~w; cmd_addr = $urandom; cmd_wdata = $urandom;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // APB slave model
    int wait_left = 0;
    initial begin
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        for (int i = 0; i < 64; i++) begin
            slave_mem[i] = '0;
            ref_mem[i]   = '0;
        end
        forever begin
            @(negedge clk);
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            if (psel && !penable) begin
                wait_left = (slave_stall_q.size() > 0) ? slave_stall_q.pop_front() : 0;
            end else if (psel && penable) begin
                if (wait_left == 0) begin
                    pready  = 1'b1;
                    pslverr = addr_err(paddr);
                    if (!pwrite) prdata = slave_mem[paddr[7:2]];
                    else if (!pslverr) slave_mem[paddr[7:2]] = pwdata;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Response monitor and APB protocol checks
    exp_t cur_exp;
    int   hold_left = 0;
    logic prev_rv = 1'b0;
    initial begin
        rsp_ready = 1'b0;
        cur_exp.rdata = '0; cur_exp.err = 1'b0; cur_exp.rsp_cyc = 0; cur_exp.hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rv = 1'b0;
            end else begin
                if (penable) check("psel_with_penable", 64'(psel), 64'd1);
                if (psel) begin
                    check("paddr_stable", 64'(paddr), 64'(cur_addr));
                    check("pwrite_stable", 64'(pwrite), 64'(cur_write));
                    if (cur_write) check("pwdata_stable", 64'(pwdata), 64'(cur_wdata));
                end
                if (rsp_valid) begin
                    check("psel_in_resp", 64'(psel), 64'd0);
                    if (!prev_rv) begin
                        if (sb_q.size() == 0) begin
                            check("unexpected_rsp", 64'd1, 64'd0);
                        end else begin
                            cur_exp = sb_q.pop_front();
                            check("rsp_rdata", 64'(rsp_rdata), 64'(cur_exp.rdata));
                            check("rsp_err", 64'(rsp_err), 64'(cur_exp.err));
                            check("rsp_latency", 64'(cyc), 64'(cur_exp.rsp_cyc));
                            hold_left = cur_exp.hold;
                        end
                    end else begin
                        check("rsp_rdata_held", 64'(rsp_rdata), 64'(cur_exp.rdata));
                        check("rsp_err_held", 64'(rsp_err), 64'(cur_exp.err));
                        check("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
                    end
                    if (hold_left > 0) begin
                        rsp_ready = 1'b0;
                        hold_left--;
                    end else begin
                        rsp_ready = ($urandom_range(0, 2) != 0);
                    end
                end else begin
                    rsp_ready = 1'($urandom_range(0, 1));
                end
                prev_rv = rsp_valid;
            end
        end
    end

    int unsigned hs;
    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // zero-wait write: setup then access phase
        issue(1'b1, 32'h08, 32'h1000_0000, 0, 0, 1'b1, hs);
        check("setup_psel", 64'(psel), 64'd1);
        check("setup_penable", 64'(penable), 64'd0);
        check("setup_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("access_penable", 64'(penable), 64'd1);
        check("access_pwdata", 64'(pwdata), 64'h1000_0000);

        issue(1'b1, 32'h24, 32'h0000_0002, 0, 0, 1'b1, hs);
        issue(1'b0, 32'h24, 32'h0, 0, 0, 1'b1, hs);

        // three wait states: ACCESS lasts four cycles
        issue(1'b0, 32'h28, 32'h0, 3, 0, 1'b1, hs);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wait_penable", 64'(penable), 64'd1);
        end
        @(negedge clk);
        check("wait_rsp_valid", 64'(rsp_valid), 64'd1);

        // slave error with a stalled consumer
        issue(1'b1, 32'h40, 32'hDEAD_BEEF, 0, 5, 1'b1, hs);

        // long stall: completes normally, or aborts when the timeout is built in
        issue(1'b0, 32'h08, 32'h0, 300, 0, 1'b1, hs);

        // reset during ACCESS discards the transfer
        issue(1'b0, 32'h30, 32'h0, 6, 0, 1'b0, hs);
        @(negedge clk);
        check("pre_reset_penable", 64'(penable), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_psel", 64'(psel), 64'd0);
        check("mid_rst_penable", 64'(penable), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        rst_n = 1'b1;

        issue(1'b1, 32'h0C, 32'h1234_5678, 1, 0, 1'b1, hs);
        issue(1'b0, 32'h0C, 32'h0, 0, 0, 1'b1, hs);

        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                  $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 1'b1, hs);
        end

        begin
            int n;
            n = 0;
            while ((sb_q.size() != 0 || !cmd_ready) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("drain_pending", 64'(sb_q.size()), 64'd0);
            check("drain_idle", 64'(cmd_ready), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
